// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO read-side adapter: output buffer depth and
// the occupancy width derived from it.
package fifo_pkg;

    localparam int BUF_DEPTH = 2;
    localparam int OCC_WIDTH = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/stream_buf2.sv
// Two-entry indexed output buffer: write/read indices plus occupancy count.
// Storage is registered so the read word is glitch-free and stable under stall.
module stream_buf2
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [OCC_WIDTH-1:0]  occ
);

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic                  wr_idx;
    logic                  rd_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_idx <= 1'b0;
            rd_idx <= 1'b0;
            occ    <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_idx] <= wr_data;
                wr_idx      <= ~wr_idx;
            end
            if (pop) begin
                rd_idx <= ~rd_idx;
            end
            // simultaneous write and pop leave occupancy unchanged
            case ({wr_en, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a registered-read FIFO into a valid/ready stream through a 2-entry buffer.
// Optional beat counter enabled by defining FIFO_STREAM_READER_CNT_EN.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [OCC_WIDTH-1:0]  occupancy
`ifdef FIFO_STREAM_READER_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  beat_cnt
`endif
);

    if (CNT_WIDTH < 1) begin : g_bad_cnt_width
        $error("CNT_WIDTH must be at least 1");
    end

    logic                 inflight;
    logic                 pop;
    logic                 has_credit;
    logic [OCC_WIDTH-1:0] occ;

    assign m_valid = (occ != '0);
    assign pop     = m_valid && m_ready;

    // a slot must be free for every issued read: occ + inflight never exceeds the depth
    assign has_credit = ({1'b0, occ} + {{OCC_WIDTH{1'b0}}, inflight})
                        < (OCC_WIDTH + 1)'(BUF_DEPTH);
    assign fifo_rd_en = !rst && !fifo_empty && (has_credit || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
        end
    end

    stream_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (inflight),
        .wr_data (fifo_dout),
        .pop     (pop),
        .rd_data (m_data),
        .occ     (occ)
    );

    assign occupancy = occ;

`ifdef FIFO_STREAM_READER_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (pop) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side adapter that drains the `fifo` block's registered read port and presents its contents as a valid/ready stream. It sits directly after a `fifo` instance in the same clock domain. It hides the FIFO's one-cycle read latency behind a 2-entry output buffer, so a ready consumer receives one word per cycle. It never drops or duplicates a word under any back-pressure pattern.

## Interface
Parameters:
- DATA_WIDTH, 8, word width; must equal the attached FIFO's DATA_WIDTH.
- CNT_WIDTH, 16, width of the optional beat counter.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_en  output  1  read strobe to FIFO.
- fifo_dout  input  DATA_WIDTH  FIFO registered read data; valid the cycle after an accepted read.
- m_valid  output  1  stream word available.
- m_ready  input  1  consumer accepts the word.
- m_data  output  DATA_WIDTH  stream word.
- occupancy  output  2  words held in the output buffer, 0..2.
- beat_cnt  output  CNT_WIDTH  completed handshakes; present only with FIFO_STREAM_READER_CNT_EN.

## Operation
- State:
  - 2-entry buffer `buf[0:1]` with 1-bit write and read indices.
  - `occ` (0..2).
  - 1-bit `inflight`: a read was issued last cycle.
- pop = m_valid && m_ready.
- fifo_rd_en = !rst && !fifo_empty && ((occ + inflight < 2) || pop). This is combinational, and m_ready feeds it directly; the path is accepted.
- inflight <= fifo_rd_en.
- When inflight is 1, fifo_dout is written to buf[wr_idx] and wr_idx toggles.
- On pop, rd_idx toggles.
- occ is updated by +inflight −pop; a simultaneous write and pop leaves occ unchanged.
- m_valid = (occ != 0). m_data = buf[rd_idx], registered storage only.
- The credit rule guarantees occ + inflight ≤ 2 at all times, so a returning word always has a free slot. Buffer overflow is impossible by construction.
- m_data and m_valid stay stable while m_valid && !m_ready.
- Reset, asynchronous:
  - occ = 0, inflight = 0, indices = 0, buffer contents = 0.
  - m_valid = 0, m_data = 0, fifo_rd_en = 0, occupancy = 0, beat_cnt = 0.
  - This block and its FIFO share rst. Resetting this block alone mid-operation discards any in-flight word; that is permitted, and the FIFO pointer has already advanced.

## Timing
- Empty system; FIFO goes non-empty at cycle T:
  - fifo_rd_en = 1 in T.
  - fifo_dout valid in T+1, captured at end of T+1.
  - m_valid = 1 in T+2. First-word latency is 2 cycles.
- Steady state with m_ready held high and FIFO non-empty: one word per cycle, and occ stays at 1 (a write and a pop each cycle).
- m_ready low: at most two further FIFO reads are issued, after which fifo_rd_en = 0 until a pop.
- FIFO becomes empty: fifo_rd_en drops in the same cycle. The buffered words still drain.
- Words leave in the order the FIFO produced them.

## Configuration
- FIFO_STREAM_READER_CNT_EN defined:
  - beat_cnt port exists; it increments by 1 on every pop.
  - It wraps modulo 2^CNT_WIDTH and resets to 0.
- Undefined: the beat_cnt port and counter are absent; all other behaviour is identical.

## Structure
- Shared package `fifo_pkg`: localparam BUF_DEPTH = 2, and the occupancy width derived from it.
- One sub-module: `stream_buf2`, the 2-entry indexed buffer with occ and index logic.
- Credit, fifo_rd_en and counter logic stay in the top level.

## Test plan
- Reset mid-stream with occ = 2 and inflight = 1: immediately m_valid = 0, m_data = 0, fifo_rd_en = 0, occupancy = 0. After release, the first read is issued only once fifo_empty = 0.
- Write 0x01..0x10 into an 8-bit, 16-deep FIFO with m_ready = 1: outputs are 0x01..0x10 in order on 16 consecutive cycles. The first m_valid comes 2 cycles after the first fifo_rd_en.
- FIFO holds 5 words, m_ready = 0 for 10 cycles: exactly 2 fifo_rd_en pulses, occupancy = 2, and m_data holds the first word stable. Raising m_ready then delivers all 5 words in order.
- Alternate m_ready 1/0 each cycle while the FIFO is concurrently written: no loss or duplication over 200 random words, and occ + inflight ≤ 2 every cycle (assertion).
- fifo_empty = 1 throughout: fifo_rd_en is never asserted and m_valid stays 0.
- With FIFO_STREAM_READER_CNT_EN and CNT_WIDTH = 4: after 17 pops, beat_cnt = 1 (wrap). Without the macro, the build has no beat_cnt port.
